// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU issuer block.
//   - alu_mode_e : operation encodings understood by the ALU
//   - state_e    : issuer FSM states
//   - alu_req_t  : one queued request {mode, a, b}, 66 bits
package alu_pkg;

    typedef enum logic [1:0] {
        MODE_MULU  = 2'd0,
        MODE_DIVU  = 2'd1,
        MODE_SHIFT = 2'd2,
        MODE_AVG   = 2'd3
    } alu_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;

    localparam int unsigned REQ_W = $bits(alu_req_t);

endpackage

// File: rtl/alu_issuer_if.sv
// alu_issuer_if
// Bundles the three handshakes around the issuer:
//   request  : req_valid/req_ready/req_mode/req_a/req_b   (upstream -> issuer)
//   ALU      : alu_valid/alu_mode/alu_in_A/alu_in_B, alu_ready/alu_out
//   result   : res_valid/res_ready/res_data/res_mode/res_err (issuer -> downstream)
//   status   : busy
// master = the issuer itself, slave = its environment (source, ALU, sink).
interface alu_issuer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_mode;
    logic [31:0] req_a;
    logic [31:0] req_b;

    logic        alu_valid;
    logic [1:0]  alu_mode;
    logic [31:0] alu_in_A;
    logic [31:0] alu_in_B;
    logic        alu_ready;
    logic [63:0] alu_out;

    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic [1:0]  res_mode;
    logic        res_err;

    logic        busy;

    modport master (
        input  req_valid, req_mode, req_a, req_b,
        output req_ready,
        output alu_valid, alu_mode, alu_in_A, alu_in_B,
        input  alu_ready, alu_out,
        output res_valid, res_data, res_mode, res_err,
        input  res_ready,
        output busy
    );

    modport slave (
        output req_valid, req_mode, req_a, req_b,
        input  req_ready,
        input  alu_valid, alu_mode, alu_in_A, alu_in_B,
        output alu_ready, alu_out,
        input  res_valid, res_data, res_mode, res_err,
        output res_ready,
        input  busy
    );
endinterface

// File: rtl/alu_req_fifo.sv
// alu_req_fifo
// Synchronous request FIFO, DEPTH x alu_req_t. Pointers carry one extra MSB
// so full and empty are told apart without a separate counter.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_push, i_data      write request (ignored when full)
//   i_pop               advance head (ignored when empty)
//   o_data              current head entry (valid while !o_empty)
//   o_full, o_empty     status flags
module alu_req_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     i_push,
    input  alu_req_t i_data,
    input  logic     i_pop,
    output alu_req_t o_data,
    output logic     o_full,
    output logic     o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_push;
    logic        w_pop;
    alu_req_t    w_entries [DEPTH];

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // One register per entry; the head is read combinationally so the
    // issuer can pop and load operands on the same edge.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            alu_req_t r_entry;
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr[AW-1:0] == AW'(gi))) begin
                    r_entry <= i_data;
                end
            end
            assign w_entries[gi] = r_entry;
        end
    endgenerate

    assign o_data = w_entries[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/alu_issuer.sv
// alu_issuer
// Initiator side of the multi-cycle ALU handshake. Requests are queued in
// alu_req_fifo, issued one at a time (one-cycle alu_valid pulse), the result
// is captured on alu_ready and held on the result port until res_ready.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset (flushes FIFO, drops in-flight op)
//   bus  alu_issuer_if.master: request, ALU and result handshakes plus busy
// Parameters:
//   DEPTH    request FIFO entries (power of two, >= 2)
//   TIMEOUT  WAIT watchdog limit in cycles (only with ALU_ISSUE_TIMEOUT_EN)
// Build option:
//   ALU_ISSUE_TIMEOUT_EN  enables the WAIT watchdog; when it expires the op
//                         returns res_data=0, res_err=1. Without it res_err=0.
module alu_issuer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
`ifdef ALU_ISSUE_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 64
`endif
) (
    input logic          clk,
    input logic          rst,
    alu_issuer_if.master bus
);
    state_e      r_state;
    logic        r_alu_valid;
    logic [1:0]  r_mode;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_res_valid;
    logic [63:0] r_res_data;
    logic [1:0]  r_res_mode;

    alu_req_t    w_req;
    alu_req_t    w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;

    assign w_req = '{mode: bus.req_mode, a: bus.req_a, b: bus.req_b};

    // Pop whenever the FSM is ready for a new op; the FIFO ignores it when empty.
    assign w_pop = (r_state == ST_IDLE) ||
                   ((r_state == ST_HOLD) && bus.res_ready);

    alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (bus.req_valid),
        .i_data  (w_req),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef ALU_ISSUE_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_res_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_alu_valid <= 1'b0;
            r_mode      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_mode  <= '0;
`ifdef ALU_ISSUE_TIMEOUT_EN
            r_wd_cnt    <= '0;
            r_res_err   <= 1'b0;
`endif
        end else begin
            r_alu_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_mode      <= w_head.mode;
                        r_a         <= w_head.a;
                        r_b         <= w_head.b;
                        r_alu_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef ALU_ISSUE_TIMEOUT_EN
                    r_wd_cnt <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.alu_ready) begin
                        r_res_data  <= bus.alu_out;
                        r_res_mode  <= r_mode;
                        r_res_valid <= 1'b1;
`ifdef ALU_ISSUE_TIMEOUT_EN
                        r_res_err   <= 1'b0;
`endif
                        r_state     <= ST_HOLD;
                    end
`ifdef ALU_ISSUE_TIMEOUT_EN
                    // Counter value TIMEOUT-1 here means TIMEOUT WAIT cycles elapsed.
                    else if (r_wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        r_res_data  <= '0;
                        r_res_mode  <= r_mode;
                        r_res_valid <= 1'b1;
                        r_res_err   <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    end
`endif
                end
                ST_HOLD: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        if (!w_empty) begin
                            r_mode      <= w_head.mode;
                            r_a         <= w_head.a;
                            r_b         <= w_head.b;
                            r_alu_valid <= 1'b1;
                            r_state     <= ST_ISSUE;
                        end else begin
                            // Operands read as zero whenever nothing is issued.
                            r_mode  <= '0;
                            r_a     <= '0;
                            r_b     <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = !w_full;
    assign bus.alu_valid = r_alu_valid;
    assign bus.alu_mode  = r_mode;
    assign bus.alu_in_A  = r_a;
    assign bus.alu_in_B  = r_b;
    assign bus.res_valid = r_res_valid;
    assign bus.res_data  = r_res_data;
    assign bus.res_mode  = r_res_mode;
    assign bus.busy      = (r_state != ST_IDLE) || !w_empty;
`ifdef ALU_ISSUE_TIMEOUT_EN
    assign bus.res_err   = r_res_err;
`else
    assign bus.res_err   = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issuer.sv
// tb_alu_issuer
// Self-checking bench for alu_issuer: behavioural ALU (mul/div 33 cycles,
// shift/avg 2 cycles), scoreboard of expected results filled on request
// accept and drained on result accept. Timeout scenario runs only when
// ALU_ISSUE_TIMEOUT_EN is defined.
module tb_alu_issuer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issuer_if bus();

    alu_issuer #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    logic alu_stall   = 1'b0;
    logic force_ready = 1'b0;
    logic exp_timeout = 1'b0;
    logic model_kill  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] alu_ref(input logic [1:0] m, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [32:0] s;
        case (m)
            MODE_MULU:  return {32'd0, a} * {32'd0, b};
            MODE_DIVU:  return (b == 32'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : {a % b, a / b};
            MODE_SHIFT: return {32'd0, a << b[4:0]};
            default: begin
                s = {1'b0, a} + {1'b0, b};
                return {32'd0, s[32:1]};
            end
        endcase
    endfunction

    // Behavioural ALU: latches operands on alu_valid, answers after latency.
    initial begin
        logic        m_busy, m_unst, m_rdy_prev;
        int          m_cnt;
        logic [1:0]  m_mode;
        logic [31:0] m_a, m_b;
        m_busy = 0; m_unst = 0; m_rdy_prev = 0; m_cnt = 0;
        m_mode = 0; m_a = 0; m_b = 0;
        bus.alu_ready = 1'b0;
        bus.alu_out   = 64'd0;
        forever begin
            @(negedge clk);
            bus.alu_ready = 1'b0;
            if (rst || model_kill) begin
                m_busy = 0;
                m_rdy_prev = 0;
            end else begin
                if (m_rdy_prev) chk("res_latency", 64'(bus.res_valid), 64'd1);
                m_rdy_prev = 0;
                if (m_busy) begin
                    if (bus.alu_in_A !== m_a || bus.alu_in_B !== m_b || bus.alu_mode !== m_mode)
                        m_unst = 1;
                    if (m_cnt > 0) m_cnt--;
                    if (m_cnt == 0 && !alu_stall) begin
                        chk("operand_stable", 64'(m_unst), 64'd0);
                        bus.alu_ready = 1'b1;
                        bus.alu_out   = alu_ref(m_mode, m_a, m_b);
                        m_busy = 0;
                        m_rdy_prev = 1;
                    end
                end
                if (bus.alu_valid) begin
                    chk("one_outstanding", 64'(m_busy), 64'd0);
                    m_busy = 1;
                    m_mode = bus.alu_mode;
                    m_a    = bus.alu_in_A;
                    m_b    = bus.alu_in_B;
                    m_cnt  = (bus.alu_mode == MODE_MULU || bus.alu_mode == MODE_DIVU) ? 33 : 2;
                    m_unst = 0;
                end
            end
            if (force_ready) begin
                bus.alu_ready = 1'b1;
                bus.alu_out   = 64'hDEAD_BEEF_0BAD_F00D;
            end
        end
    end

    // Scoreboard monitor: push on request accept, pop/compare on result accept.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.req_valid && bus.req_ready) begin
                mon_e.mode = bus.req_mode;
                mon_e.data = exp_timeout ? 64'd0 : alu_ref(bus.req_mode, bus.req_a, bus.req_b);
                mon_e.err  = exp_timeout;
                sb.push_back(mon_e);
            end
            if (bus.res_valid && bus.res_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    $display("txn mode=%0d data=%016h err=%0b", bus.res_mode, bus.res_data, bus.res_err);
                    chk("res_data", bus.res_data, mon_e.data);
                    chk("res_mode", 64'(bus.res_mode), 64'(mon_e.mode));
                    chk("res_err", 64'(bus.res_err), 64'(mon_e.err));
                end
            end
        end
    end

    task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        int t;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_mode  = m;
        bus.req_a     = a;
        bus.req_b     = b;
        t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        @(negedge clk);
        while ((sb.size() != 0 || bus.busy) && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 64'(sb.size() == 0 && !bus.busy), 64'd1);
    endtask

    task automatic wait_res_valid(input int budget);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.res_valid && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk("wait_res_valid", 64'(bus.res_valid), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  fm [6];
        logic [31:0] fa [6];
        logic [31:0] fb [6];
        logic [31:0] ha;
        int acc, idx, nv, nr, n;
        logic fire;

        bus.req_valid = 1'b0;
        bus.req_mode  = 2'd0;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.res_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_alu_valid", 64'(bus.alu_valid), 64'd0);
        chk("rst_alu_mode", 64'(bus.alu_mode), 64'd0);
        chk("rst_alu_in_A", 64'(bus.alu_in_A), 64'd0);
        chk("rst_alu_in_B", 64'(bus.alu_in_B), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_res_data", bus.res_data, 64'd0);
        chk("rst_res_mode", 64'(bus.res_mode), 64'd0);
        chk("rst_res_err", 64'(bus.res_err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single mulu 7*6 with issue timing
        bus.res_ready = 1'b1;
        send(MODE_MULU, 32'd7, 32'd6);
        @(negedge clk);
        chk("pre_issue_valid", 64'(bus.alu_valid), 64'd0);
        @(negedge clk);
        chk("issue_valid", 64'(bus.alu_valid), 64'd1);
        chk("issue_A", 64'(bus.alu_in_A), 64'd7);
        chk("issue_B", 64'(bus.alu_in_B), 64'd6);
        chk("issue_mode", 64'(bus.alu_mode), 64'd0);
        @(negedge clk);
        chk("issue_pulse", 64'(bus.alu_valid), 64'd0);
        drain(200);
        chk("idle_A_zero", 64'(bus.alu_in_A), 64'd0);
        chk("idle_B_zero", 64'(bus.alu_in_B), 64'd0);

        // Fill: ALU stalled, sink blocked, 6 requests offered
        for (int i = 0; i < 6; i++) begin
            fm[i] = 2'(i % 4);
            fa[i] = $urandom;
            fb[i] = $urandom_range(1, 1000);
        end
        @(posedge clk); #1;
        alu_stall = 1'b1;
        bus.res_ready = 1'b0;
        acc = 0;
        idx = 0;
        bus.req_valid = 1'b1;
        bus.req_mode = fm[0]; bus.req_a = fa[0]; bus.req_b = fb[0];
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            fire = bus.req_valid && bus.req_ready;
            @(posedge clk); #1;
            if (fire) begin
                acc++;
                idx++;
                if (idx < 6) begin
                    bus.req_mode = fm[idx]; bus.req_a = fa[idx]; bus.req_b = fb[idx];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk("fill_accepted", 64'(acc), 64'd5);
        chk("fill_req_ready", 64'(bus.req_ready), 64'd0);
        chk("fill_busy", 64'(bus.busy), 64'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        alu_stall = 1'b0;
        bus.res_ready = 1'b1;
        drain(1000);

        // Hold: result parked 10 cycles, then back-to-back issue
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        ha = $urandom;
        send(MODE_SHIFT, ha, 32'd3);
        send(MODE_AVG, 32'hFFFF_FFFF, 32'd5);
        wait_res_valid(50);
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("hold_data", bus.res_data, alu_ref(MODE_SHIFT, ha, 32'd3));
            if (bus.alu_valid) nv++;
        end
        chk("hold_no_issue", 64'(nv), 64'd0);
        chk("hold_res_valid", 64'(bus.res_valid), 64'd1);
        @(posedge clk); #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("next_issue", 64'(bus.alu_valid), 64'd1);
        drain(100);

`ifdef ALU_ISSUE_TIMEOUT_EN
        // Watchdog: ALU never answers
        @(posedge clk); #1;
        alu_stall = 1'b1;
        exp_timeout = 1'b1;
        send(MODE_MULU, 32'd3, 32'd5);
        exp_timeout = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.alu_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("to_issue_seen", 64'(bus.alu_valid), 64'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid && n < 200);
        chk("timeout_cycles", 64'(n), 64'd65);
        @(posedge clk); #1;
        model_kill = 1'b1;
        alu_stall = 1'b0;
        @(posedge clk); #1;
        model_kill = 1'b0;
        send(MODE_AVG, 32'd10, 32'd21);
        drain(100);
`endif

        // Reset during WAIT, then spurious alu_ready
        @(posedge clk); #1;
        alu_stall = 1'b1;
        send(MODE_DIVU, 32'd100, 32'd7);
        send(MODE_SHIFT, 32'd1, 32'd4);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        alu_stall = 1'b0;
        force_ready = 1'b1;
        nr = 0;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == 3) force_ready = 1'b0;
            @(negedge clk);
            if (bus.res_valid) nr++;
            if (bus.alu_valid) nv++;
        end
        chk("rstw_res_valid", 64'(nr), 64'd0);
        chk("rstw_alu_valid", 64'(nv), 64'd0);
        chk("rstw_busy", 64'(bus.busy), 64'd0);
        chk("rstw_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rstw_res_data", bus.res_data, 64'd0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
